sm_addsub_pipe: RTL and testbench
=================================

SM_ADDSUB_PIPE -- requirements
Module: sm_addsub_pipe

Interface
REQ-001 The block SHALL have parameter MAG_W, default 8: magnitude bits per operand and result; operand and result are sign bit plus MAG_W magnitude bits.
REQ-002 The block SHALL have parameter SAT, default 0: 0 = wrap on overflow, 1 = saturate on overflow.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts the operand pair this cycle.
REQ-007 The block SHALL have port op, input, 1 bit: 0 = A+B, 1 = A-B; qualified by in_valid.
REQ-008 The block SHALL have port numberA, input, MAG_W+1 bits: bit MAG_W is the sign (1 = negative), the low bits are the magnitude.
REQ-009 The block SHALL have port numberB, input, MAG_W+1 bits: same format as numberA.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port Result, output, MAG_W+1 bits: sign-magnitude result.
REQ-013 The block SHALL have port ovf, output, 1 bit: true magnitude exceeded 2^MAG_W-1; qualified by out_valid.
REQ-014 The block SHALL have port ovf_cnt, output, 16 bits: count of overflowed results delivered.
REQ-015 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of ovf_cnt.

Function
REQ-016 An input transfer SHALL occur when in_valid && in_ready are both high on a rising clk edge; an output transfer SHALL occur when out_valid && out_ready are both high.
REQ-017 The pipeline SHALL have 2 register stages: S1 holds the effective-op decode, the magnitude compare and the larger/smaller swap; S2 holds the result and ovf. Latency SHALL be 2 cycles from input transfer to out_valid when the path is unstalled.
REQ-018 Throughput SHALL be 1 operation per cycle when out_ready=1.
REQ-019 Effective B sign SHALL be B.sign XOR op. If A.sign equals the effective B sign: magnitude = |A|+|B| and sign = A.sign. Otherwise: magnitude = larger - smaller and sign = sign of the larger-magnitude operand.
REQ-020 On equal magnitudes with differing effective signs, the result SHALL be +0.
REQ-021 An input of -0 SHALL be treated as +0. A zero result SHALL always have sign 0; negative zero is never emitted.
REQ-022 ovf SHALL be 1 when the addition carries out of MAG_W bits. With SAT=0, Result magnitude SHALL be the sum mod 2^MAG_W. With SAT=1, Result magnitude SHALL be 2^MAG_W-1. In both cases the sign SHALL be kept.
REQ-023 S2 SHALL load when it is empty or its output transfers in that cycle; S1 SHALL load when it is empty or it advances into S2.
REQ-024 in_ready SHALL be !(S1 full && S2 full && !out_ready); a combinational path from out_ready to in_ready is permitted.
REQ-025 While out_valid=1 and out_ready=0, Result, ovf and out_valid SHALL hold stable.
REQ-026 Simultaneous input and output transfers with both stages full SHALL lose no data and duplicate no data.
REQ-027 ovf_cnt SHALL increment by 1 on each output transfer with ovf=1.
REQ-028 ovf_cnt SHALL saturate at 16'hFFFF.
REQ-029 clr_cnt SHALL have priority over increment: ovf_cnt is 0 on the next edge.

Reset
REQ-030 rst_n low SHALL asynchronously force S1 valid=0, S2 valid=0, out_valid=0, Result=0, ovf=0 and ovf_cnt=0; in_ready SHALL read 1 while in reset.
REQ-031 Operations in flight when reset asserts SHALL be discarded and never emitted.
REQ-032 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification (MAG_W=8)
REQ-033 The bench SHALL cover: SAT=0, A=+5, B=+3, op=1, out_ready=1 -> Result=+2 (9'h002), ovf=0, out_valid exactly 2 cycles after the transfer.
REQ-034 The bench SHALL cover: A=+3, B=+5, op=1 -> Result=-2 (9'h102); A=-5, B=-5, op=1 -> Result=9'h000 with sign 0.
REQ-035 The bench SHALL cover: A=+200, B=-100, op=1 -> SAT=0: Result=+44, ovf=1; SAT=1: Result=+255, ovf=1; ovf_cnt increments by 1 per delivered result.
REQ-036 The bench SHALL cover: out_ready=0, in_valid=1 for 4 cycles with distinct operands -> exactly 2 transfers accepted, in_ready=0 thereafter, Result stable; then out_ready=1 -> all results delivered in issue order with no loss or duplicate.
REQ-037 The bench SHALL cover: rst_n pulsed low with both stages full -> out_valid=0 immediately (asynchronous), ovf_cnt=0, no stale result emitted after release.
REQ-038 The bench SHALL cover: clr_cnt=1 in the same cycle as an ovf=1 output transfer -> ovf_cnt=0; ovf_cnt preset to 16'hFFFF plus a further overflow -> ovf_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready flow control.
// S1 resolves effective op and orders magnitudes; S2 forms the result, ovf and ovf_cnt.
module sm_addsub_pipe #(
  parameter int unsigned MAG_W = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [MAG_W:0]   numberA,
  input  logic [MAG_W:0]   numberB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   Result,
  output logic             ovf,
  output logic [15:0]      ovf_cnt,
  input  logic             clr_cnt
);

  logic               s1_v_q, s1_v_d;
  logic               s1_add_q, s1_add_d;
  logic               s1_sign_q, s1_sign_d;
  logic [MAG_W-1:0]   s1_big_q, s1_big_d;
  logic [MAG_W-1:0]   s1_small_q, s1_small_d;

  logic               s2_v_q, s2_v_d;
  logic [MAG_W:0]     res_q, res_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               s2_load, s1_load, in_xfer, out_xfer;
  logic [MAG_W-1:0]   a_mag, b_mag;
  logic               a_neg, b_eff, a_ge_b;
  logic [MAG_W:0]     sum;
  logic [MAG_W-1:0]   diff, mag;
  logic               carry;

  assign s2_load  = !s2_v_q || out_ready;
  assign s1_load  = !s1_v_q || s2_load;
  assign in_ready = s1_load;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_v_q && out_ready;

  assign out_valid = s2_v_q;
  assign Result    = res_q;
  assign ovf       = ovf_q;
  assign ovf_cnt   = cnt_q;

  // -0 is folded to +0 before the sign compare so it never steers the result sign.
  always_comb begin
    a_mag  = numberA[MAG_W-1:0];
    b_mag  = numberB[MAG_W-1:0];
    a_neg  = numberA[MAG_W] && (a_mag != '0);
    b_eff  = (numberB[MAG_W] && (b_mag != '0)) ^ op;
    a_ge_b = (a_mag >= b_mag);
  end

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_add_d   = s1_add_q;
    s1_sign_d  = s1_sign_q;
    s1_big_d   = s1_big_q;
    s1_small_d = s1_small_q;
    if (s1_load) begin
      s1_v_d = in_valid;
    end
    if (in_xfer) begin
      s1_add_d   = (a_neg == b_eff);
      s1_big_d   = a_ge_b ? a_mag : b_mag;
      s1_small_d = a_ge_b ? b_mag : a_mag;
      if (a_neg == b_eff) begin
        s1_sign_d = a_neg;
      end else begin
        s1_sign_d = a_ge_b ? a_neg : b_eff;
      end
    end
  end

  always_comb begin
    sum   = {1'b0, s1_big_q} + {1'b0, s1_small_q};
    diff  = s1_big_q - s1_small_q;
    carry = s1_add_q && sum[MAG_W];
    if (!s1_add_q) begin
      mag = diff;
    end else if (carry && SAT) begin
      mag = '1;
    end else begin
      mag = sum[MAG_W-1:0];
    end
  end

  always_comb begin
    s2_v_d = s2_v_q;
    res_d  = res_q;
    ovf_d  = ovf_q;
    if (s2_load) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        res_d = {s1_sign_q && (mag != '0), mag};
        ovf_d = carry;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (out_xfer && ovf_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_add_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
      s2_v_q     <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_add_q   <= s1_add_d;
      s1_sign_q  <= s1_sign_d;
      s1_big_q   <= s1_big_d;
      s1_small_q <= s1_small_d;
      s2_v_q     <= s2_v_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe: SAT=0 and SAT=1 instances share stimulus
// and are checked against a signed-integer reference model with an in-order queue.
module tb_sm_addsub_pipe;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, op, out_ready, clr_cnt;
  logic [W:0]   numberA, numberB;
  logic         in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [W:0]   res0, res1;
  logic [15:0]  cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.MAG_W(W), .SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .op(op),
    .numberA(numberA), .numberB(numberB), .out_valid(out_valid0), .out_ready(out_ready),
    .Result(res0), .ovf(ovf0), .ovf_cnt(cnt0), .clr_cnt(clr_cnt));

  sm_addsub_pipe #(.MAG_W(W), .SAT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
    .numberA(numberA), .numberB(numberB), .out_valid(out_valid1), .out_ready(out_ready),
    .Result(res1), .ovf(ovf1), .ovf_cnt(cnt1), .clr_cnt(clr_cnt));

  typedef struct {
    logic [W:0] a;
    logic [W:0] b;
    logic       o;
  } op_t;

  op_t          q[$];
  int unsigned  exp_cnt = 0;
  bit           hold_v = 1'b0;
  logic [W:0]   hold_r0, hold_r1;
  logic         hold_o;

  // Returns {ovf, sign, magnitude} computed from signed integer arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W:0] a, input logic [W:0] b,
                                             input logic o, input bit sat);
    int av, bv, r, m;
    logic s, ov;
    logic [W-1:0] mg;
    av = int'(a[W-1:0]);
    if (a[W]) av = -av;
    bv = int'(b[W-1:0]);
    if (b[W] ^ o) bv = -bv;
    r  = av + bv;
    s  = (r < 0);
    m  = s ? -r : r;
    ov = (m > (1 << W) - 1);
    if (ov && sat) m = (1 << W) - 1;
    else           m = m % (1 << W);
    mg = W'(m);
    if (m == 0) s = 1'b0;
    return {ov, s, mg};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
      hold_v  = 1'b0;
    end else begin
      logic [W+1:0] e0, e1;
      bit xovf;
      op_t e;
      xovf = 1'b0;
      chk("ovf_cnt0", {16'h0, cnt0}, exp_cnt);
      chk("ovf_cnt1", {16'h0, cnt1}, exp_cnt);
      if (in_ready0 !== in_ready1 || out_valid0 !== out_valid1) begin
        chk("handshake_agree", {in_ready1, out_valid1}, {in_ready0, out_valid0});
      end
      if (hold_v) begin
        chk("hold_valid", {31'h0, out_valid0}, 1);
        chk("hold_res0", {23'h0, res0}, {23'h0, hold_r0});
        chk("hold_res1", {23'h0, res1}, {23'h0, hold_r1});
        chk("hold_ovf", {31'h0, ovf0}, {31'h0, hold_o});
      end
      if (out_valid0 && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {23'h0, res0}, 32'hFFFF_FFFF);
        end else begin
          e  = q.pop_front();
          e0 = ref_model(e.a, e.b, e.o, 1'b0);
          e1 = ref_model(e.a, e.b, e.o, 1'b1);
          chk("res_sat0", {23'h0, res0}, {23'h0, e0[W:0]});
          chk("ovf_sat0", {31'h0, ovf0}, {31'h0, e0[W+1]});
          chk("res_sat1", {23'h0, res1}, {23'h0, e1[W:0]});
          chk("ovf_sat1", {31'h0, ovf1}, {31'h0, e1[W+1]});
          xovf = e0[W+1];
        end
      end
      if (clr_cnt)                        exp_cnt = 0;
      else if (xovf && exp_cnt < 32'hFFFF) exp_cnt = exp_cnt + 1;
      hold_v  = out_valid0 && !out_ready;
      hold_r0 = res0;
      hold_r1 = res1;
      hold_o  = ovf0;
      if (in_valid && in_ready0) q.push_back('{a: numberA, b: numberB, o: op});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W:0] a, input logic [W:0] b, input logic o);
    bit ok;
    ok       = 1'b0;
    numberA  = a;
    numberB  = b;
    op       = o;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("send_accept", {31'h0, ok}, 1);
  endtask

  task automatic expect_now(input string name, input logic [W:0] r0, input logic [W:0] r1,
                            input logic o);
    chk({name, "_valid"}, {31'h0, out_valid0}, 1);
    chk({name, "_res0"}, {23'h0, res0}, {23'h0, r0});
    chk({name, "_res1"}, {23'h0, res1}, {23'h0, r1});
    chk({name, "_ovf"}, {31'h0, ovf0}, {31'h0, o});
  endtask

  function automatic logic [W:0] rnd_operand();
    logic [W:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 3))
      0:       v = {1'($urandom), {W{1'b0}}};
      1:       v = {1'($urandom), W'(8'hFF - 8'($urandom_range(0, 15)))};
      default: v = {1'($urandom), W'($urandom)};
    endcase
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    numberA = '0; numberB = '0;

    chk("pin_5m3",    {22'h0, ref_model(9'h005, 9'h003, 1'b1, 1'b0)}, 32'h002);
    chk("pin_3m5",    {22'h0, ref_model(9'h003, 9'h005, 1'b1, 1'b0)}, 32'h102);
    chk("pin_n5mn5",  {22'h0, ref_model(9'h105, 9'h105, 1'b1, 1'b0)}, 32'h000);
    chk("pin_ovf_w",  {22'h0, ref_model(9'h0C8, 9'h164, 1'b1, 1'b0)}, 32'h22C);
    chk("pin_ovf_s",  {22'h0, ref_model(9'h0C8, 9'h164, 1'b1, 1'b1)}, 32'h2FF);

    #3;
    chk("rst_in_ready", {31'h0, in_ready0}, 1);
    chk("rst_out_valid", {31'h0, out_valid0}, 0);
    chk("rst_result", {23'h0, res0}, 0);
    chk("rst_ovf", {31'h0, ovf0}, 0);
    chk("rst_cnt", {16'h0, cnt0}, 0);
    cyc();
    #1 rst_n = 1'b1;

    // +5 - +3, two-cycle latency
    send(9'h005, 9'h003, 1'b1);
    chk("lat_not_yet", {31'h0, out_valid0}, 0);
    cyc();
    expect_now("sub_pos", 9'h002, 9'h002, 1'b0);
    cyc();

    send(9'h003, 9'h005, 1'b1);
    cyc();
    expect_now("sub_neg", 9'h102, 9'h102, 1'b0);
    cyc();
    send(9'h105, 9'h105, 1'b1);
    cyc();
    expect_now("neg_zero", 9'h000, 9'h000, 1'b0);
    cyc();

    send(9'h0C8, 9'h164, 1'b1);
    cyc();
    expect_now("ovf", 9'h02C, 9'h0FF, 1'b1);
    cyc();
    chk("ovf_cnt_one0", {16'h0, cnt0}, 1);
    chk("ovf_cnt_one1", {16'h0, cnt1}, 1);

    // Backpressure: only two of four offered operands fit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      numberA = 9'(10 + i);
      numberB = 9'(i);
      op      = 1'b0;
      @(negedge clk);
      if (in_ready0) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("stall_accepted", acc, 2);
    chk("stall_in_ready", {31'h0, in_ready0}, 0);
    repeat (3) cyc();
    expect_now("stall_head", 9'h00A, 9'h00A, 1'b0);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("stall_drained", {31'h0, out_valid0}, 0);
    chk("stall_queue", q.size(), 0);

    // clr_cnt coincident with an overflowing output transfer
    send(9'h0C8, 9'h064, 1'b0);
    cyc();
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr_prio0", {16'h0, cnt0}, 0);
    chk("clr_prio1", {16'h0, cnt1}, 0);

    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      numberA   = rnd_operand();
      numberB   = rnd_operand();
      if ($urandom_range(0, 7) == 0) numberB[W-1:0] = numberA[W-1:0];
      op        = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt   = ($urandom_range(0, 63) == 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (4) cyc();
    chk("rand_drained", q.size(), 0);

    // Reset with both stages full
    send(9'h0C8, 9'h064, 1'b0);
    repeat (2) cyc();
    out_ready = 1'b0;
    send(9'h011, 9'h022, 1'b0);
    send(9'h033, 9'h044, 1'b0);
    chk("full_before_rst", {31'h0, out_valid0}, 1);
    chk("cnt_before_rst", {31'h0, (cnt0 != 16'h0)}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid0", {31'h0, out_valid0}, 0);
    chk("async_out_valid1", {31'h0, out_valid1}, 0);
    chk("async_cnt", {16'h0, cnt0}, 0);
    chk("async_result", {23'h0, res0}, 0);
    chk("async_in_ready", {31'h0, in_ready0}, 1);
    cyc();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    numberA = 9'h005; numberB = 9'h003; op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("first_edge_ready", {31'h0, in_ready0}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc();
    expect_now("post_rst", 9'h008, 9'h008, 1'b0);
    repeat (3) cyc();
    chk("no_stale", {31'h0, out_valid0}, 0);

    // Drive the counter to its ceiling, then overflow once more
    numberA = 9'h0C8; numberB = 9'h064; op = 1'b0; in_valid = 1'b1;
    repeat (65535) cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("cnt_full0", {16'h0, cnt0}, 32'hFFFF);
    send(9'h0C8, 9'h064, 1'b0);
    repeat (2) cyc();
    chk("cnt_sat0", {16'h0, cnt0}, 32'hFFFF);
    chk("cnt_sat1", {16'h0, cnt1}, 32'hFFFF);
    chk("final_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
